// File: rtl/pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_sequencer
// Description : Wishbone master that programs PWM timer channels on behalf of
//               several round-robin arbitrated requesters. Each request is
//               validated and then issued as the write sequence
//               divisor -> period -> duty -> control. The period register can
//               optionally be read back afterwards to confirm it.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_sequencer #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_CHANNELS = 4,
  parameter int TIMEOUT      = 15,
  parameter int VERIFY       = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [3*NUM_REQ-1:0]    i_req_ch,
  input  logic [16*NUM_REQ-1:0]   i_req_div,
  input  logic [16*NUM_REQ-1:0]   i_req_per,
  input  logic [16*NUM_REQ-1:0]   i_req_dc,
  input  logic [8*NUM_REQ-1:0]    i_req_ctrl,
  output logic                    o_done,
  output logic [2:0]              o_done_id,
  output logic [1:0]              o_done_status,
  output logic                    o_busy,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [15:0]             o_wb_adr,
  output logic [15:0]             o_wb_data,
  input  logic                    i_wb_ack,
  input  logic [15:0]             i_wb_data
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    CHECK  = 4'd1,
    W_DIV  = 4'd2,
    W_PER  = 4'd3,
    W_DC   = 4'd4,
    W_CTRL = 4'd5,
    R_PER  = 4'd6,
    GAP    = 4'd7,
    DONE   = 4'd8
  } state_t;

  // Register offsets inside a channel's address window.
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DIV  = 3'd1;
  localparam logic [2:0] REG_PER  = 3'd2;
  localparam logic [2:0] REG_DC   = 3'd3;

  state_t state_q, state_d;
  state_t ret_q, ret_d;          // state to resume after the GAP cycle
  logic [2:0]  rr_q, rr_d;
  logic [2:0]  id_q, id_d;
  logic [2:0]  ch_q, ch_d;
  logic [15:0] div_q, div_d;
  logic [15:0] per_q, per_d;
  logic [15:0] dc_q, dc_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               done_q, done_d;
  logic [2:0]         done_id_q, done_id_d;
  logic [1:0]         done_status_q, done_status_d;
  logic               busy_q, busy_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [15:0]        adr_q, adr_d;
  logic [15:0]        data_q, data_d;

  logic found;
  int   gnt;
  int   idx;

  // Next-state, request capture and registered-output precomputation.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    rr_d          = rr_q;
    id_d          = id_q;
    ch_d          = ch_q;
    div_d         = div_q;
    per_d         = per_q;
    dc_d          = dc_q;
    ctrl_d        = ctrl_q;
    status_d      = status_q;
    tmo_d         = 8'd0;
    ready_d       = '0;
    done_d        = 1'b0;
    done_id_d     = 3'd0;
    done_status_d = 2'd0;
    busy_d        = 1'b0;
    cyc_d         = 1'b0;
    we_d          = 1'b0;
    adr_d         = 16'd0;
    data_d        = 16'd0;
    found         = 1'b0;
    gnt           = 0;
    idx           = 0;

    // First pending requester at or after the round-robin pointer.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          ready_d[gnt] = 1'b1;
          id_d         = 3'(gnt);
          ch_d         = i_req_ch[3*gnt +: 3];
          div_d        = i_req_div[16*gnt +: 16];
          per_d        = i_req_per[16*gnt +: 16];
          dc_d         = i_req_dc[16*gnt +: 16];
          ctrl_d       = i_req_ctrl[8*gnt +: 8];
          status_d     = 2'd0;
          rr_d         = (gnt == NUM_REQ-1) ? 3'd0 : 3'(gnt + 1);
          state_d      = CHECK;
        end
      end
      CHECK: begin
        if (int'(ch_q) >= NUM_CHANNELS || div_q == 16'd0 || dc_q > per_q) begin
          status_d = 2'd1;
          state_d  = DONE;
        end else begin
          state_d  = W_DIV;
        end
      end
      W_DIV, W_PER, W_DC, W_CTRL, R_PER: begin
        if (i_wb_ack) begin
          state_d = GAP;
          case (state_q)
            W_DIV:   ret_d = W_PER;
            W_PER:   ret_d = W_DC;
            W_DC:    ret_d = W_CTRL;
            W_CTRL:  ret_d = (VERIFY != 0) ? R_PER : DONE;
            default: ret_d = DONE;
          endcase
          if (state_q == R_PER && i_wb_data != per_q) status_d = 2'd3;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          // TIMEOUT cycles without ack: abandon the rest of the sequence.
          status_d = 2'd2;
          state_d  = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      GAP:     state_d = ret_q;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d = (state_d != IDLE);
    case (state_d)
      W_DIV: begin
        cyc_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = {10'd0, ch_d, REG_DIV};
        data_d = div_d;
      end
      W_PER: begin
        cyc_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = {10'd0, ch_d, REG_PER};
        data_d = per_d;
      end
      W_DC: begin
        cyc_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = {10'd0, ch_d, REG_DC};
        data_d = dc_d;
      end
      W_CTRL: begin
        cyc_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = {10'd0, ch_d, REG_CTRL};
        data_d = {8'h00, ctrl_d};
      end
      R_PER: begin
        cyc_d  = 1'b1;
        adr_d  = {10'd0, ch_d, REG_PER};
      end
      DONE: begin
        done_d        = 1'b1;
        done_id_d     = id_d;
        done_status_d = status_d;
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      ret_q         <= IDLE;
      rr_q          <= 3'd0;
      id_q          <= 3'd0;
      ch_q          <= 3'd0;
      div_q         <= 16'd0;
      per_q         <= 16'd0;
      dc_q          <= 16'd0;
      ctrl_q        <= 8'd0;
      status_q      <= 2'd0;
      tmo_q         <= 8'd0;
      ready_q       <= '0;
      done_q        <= 1'b0;
      done_id_q     <= 3'd0;
      done_status_q <= 2'd0;
      busy_q        <= 1'b0;
      cyc_q         <= 1'b0;
      we_q          <= 1'b0;
      adr_q         <= 16'd0;
      data_q        <= 16'd0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      rr_q          <= rr_d;
      id_q          <= id_d;
      ch_q          <= ch_d;
      div_q         <= div_d;
      per_q         <= per_d;
      dc_q          <= dc_d;
      ctrl_q        <= ctrl_d;
      status_q      <= status_d;
      tmo_q         <= tmo_d;
      ready_q       <= ready_d;
      done_q        <= done_d;
      done_id_q     <= done_id_d;
      done_status_q <= done_status_d;
      busy_q        <= busy_d;
      cyc_q         <= cyc_d;
      we_q          <= we_d;
      adr_q         <= adr_d;
      data_q        <= data_d;
    end
  end

  assign o_req_ready   = ready_q;
  assign o_done        = done_q;
  assign o_done_id     = done_id_q;
  assign o_done_status = done_status_q;
  assign o_busy        = busy_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = cyc_q;
  assign o_wb_we       = we_q;
  assign o_wb_adr      = adr_q;
  assign o_wb_data     = data_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_cfg_sequencer
// Description : Scoreboard bench for pwm_cfg_sequencer. Directed requests push
//               expected bus accesses, grants and completions into queues; a
//               monitor pops and compares them as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_cfg_sequencer;

  localparam int NUM_REQ = 2;
  localparam int LIMIT   = 1000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [3*NUM_REQ-1:0]  req_ch;
  logic [16*NUM_REQ-1:0] req_div, req_per, req_dc;
  logic [8*NUM_REQ-1:0]  req_ctrl;
  logic                  done, busy;
  logic [2:0]            done_id;
  logic [1:0]            done_status;
  logic                  wb_cyc, wb_stb, wb_we, wb_ack;
  logic [15:0]           wb_adr, wb_data, wb_rdata;

  pwm_cfg_sequencer #(.NUM_REQ(NUM_REQ), .NUM_CHANNELS(4), .TIMEOUT(15), .VERIFY(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_ch(req_ch), .i_req_div(req_div), .i_req_per(req_per),
    .i_req_dc(req_dc), .i_req_ctrl(req_ctrl),
    .o_done(done), .o_done_id(done_id), .o_done_status(done_status), .o_busy(busy),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
    .o_wb_data(wb_data), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata)
  );

  always #5 clk = ~clk;

  // Slave model: registered ack one cycle into each access, 64-word memory.
  logic [15:0] mem [0:63];
  logic        nack_en;
  logic [2:0]  nack_reg;
  logic        rd_corrupt;

  always @(posedge clk) begin
    if (rst) begin
      wb_ack <= 1'b0;
    end else begin
      wb_ack <= wb_cyc && wb_stb && !wb_ack && !(nack_en && wb_adr[2:0] == nack_reg);
      if (wb_cyc && wb_stb && wb_we && wb_ack) mem[wb_adr[5:0]] <= wb_data;
    end
  end
  assign wb_rdata = rd_corrupt ? (mem[wb_adr[5:0]] - 16'd1) : mem[wb_adr[5:0]];

  // Scoreboard state.
  logic [32:0] exp_bus [$];    // {we, adr, data}
  logic [4:0]  exp_done [$];   // {id, status}
  int          exp_grant [$];
  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int cyc_cycles = 0;
  int last_ready_cycle = 0;
  int last_done_cycle  = 0;
  logic [NUM_REQ-1:0] prev_ready = '0;
  logic [32:0] e;
  logic [4:0]  d;
  int          g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every acked access, grant and completion.
  always @(negedge clk) begin
    cycle++;
    if (!rst) begin
      if (wb_cyc && wb_stb) cyc_cycles++;
      if (wb_cyc && wb_stb && wb_ack) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", exp_bus.size(), 1);
        end else begin
          e = exp_bus.pop_front();
          check("bus_we", {31'd0, wb_we}, {31'd0, e[32]});
          check("bus_adr", {16'd0, wb_adr}, {16'd0, e[31:16]});
          if (e[32]) check("bus_data", {16'd0, wb_data}, {16'd0, e[15:0]});
        end
      end
      if (req_ready != '0) begin
        check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
        check("ready_pulse", {30'd0, prev_ready}, 32'd0);
        last_ready_cycle = cycle;
        if (exp_grant.size() == 0) begin
          check("grant_unexpected", exp_grant.size(), 1);
        end else begin
          g = exp_grant.pop_front();
          check("grant", {30'd0, req_ready}, 32'd1 << g);
        end
      end
      if (done) begin
        last_done_cycle = cycle;
        if (exp_done.size() == 0) begin
          check("done_unexpected", exp_done.size(), 1);
        end else begin
          d = exp_done.pop_front();
          check("done_id", {29'd0, done_id}, {29'd0, d[4:2]});
          check("done_status", {30'd0, done_status}, {30'd0, d[1:0]});
        end
      end
    end
    prev_ready = req_ready;
  end

  task automatic push_bus(input logic we, input logic [15:0] adr, input logic [15:0] data);
    exp_bus.push_back({we, adr, data});
  endtask

  // Full sequence for a valid request: four writes, period read, completion.
  task automatic push_seq(input int id, input logic [2:0] ch, input logic [15:0] dv,
                          input logic [15:0] pr, input logic [15:0] dc,
                          input logic [7:0] ct, input logic [1:0] st);
    push_bus(1'b1, {10'd0, ch, 3'd1}, dv);
    push_bus(1'b1, {10'd0, ch, 3'd2}, pr);
    push_bus(1'b1, {10'd0, ch, 3'd3}, dc);
    push_bus(1'b1, {10'd0, ch, 3'd0}, {8'h00, ct});
    push_bus(1'b0, {10'd0, ch, 3'd2}, 16'd0);
    exp_done.push_back({3'(id), st});
    exp_grant.push_back(id);
  endtask

  task automatic set_fields(input int r, input logic [2:0] ch, input logic [15:0] dv,
                            input logic [15:0] pr, input logic [15:0] dc, input logic [7:0] ct);
    req_ch[3*r +: 3]    = ch;
    req_div[16*r +: 16] = dv;
    req_per[16*r +: 16] = pr;
    req_dc[16*r +: 16]  = dc;
    req_ctrl[8*r +: 8]  = ct;
  endtask

  // Waits for the ready pulse of requester r (observed at a negedge).
  task automatic wait_ready(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < LIMIT);
    check("wait_ready", {31'd0, n < LIMIT}, 32'd1);
  endtask

  task automatic issue(input int r, input logic [2:0] ch, input logic [15:0] dv,
                       input logic [15:0] pr, input logic [15:0] dc, input logic [7:0] ct);
    @(negedge clk);
    set_fields(r, ch, dv, pr, dc, ct);
    req_valid[r] = 1'b1;
    wait_ready(r);
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_bus.size() != 0 || exp_done.size() != 0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("wait_empty", {31'd0, n < LIMIT}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic serve(input int r);
    for (int i = 0; i < 4; i++) wait_ready(r);
    req_valid[r] = 1'b0;
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, "_cyc"},  {31'd0, wb_cyc}, 32'd0);
    check({tag, "_stb"},  {31'd0, wb_stb}, 32'd0);
    check({tag, "_we"},   {31'd0, wb_we}, 32'd0);
    check({tag, "_adr"},  {16'd0, wb_adr}, 32'd0);
    check({tag, "_data"}, {16'd0, wb_data}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_ready"}, {30'd0, req_ready}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    rst = 1'b1; req_valid = '0; req_ch = '0; req_div = '0; req_per = '0;
    req_dc = '0; req_ctrl = '0; nack_en = 1'b0; nack_reg = 3'd0; rd_corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check_bus_idle("reset");
    check("reset_id", {29'd0, done_id}, 32'd0);
    check("reset_status", {30'd0, done_status}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequence with hand-computed addresses and data.
    push_bus(1'b1, 16'h0009, 16'd2);
    push_bus(1'b1, 16'h000A, 16'd1000);
    push_bus(1'b1, 16'h000B, 16'd250);
    push_bus(1'b1, 16'h0008, 16'h0016);
    push_bus(1'b0, 16'h000A, 16'd0);
    exp_done.push_back({3'd0, 2'd0});
    exp_grant.push_back(0);
    issue(0, 3'd1, 16'd2, 16'd1000, 16'd250, 8'h16);
    wait_empty();
    check("latency_ready_to_done", last_done_cycle - last_ready_cycle, 32'd16);

    // Invalid parameters: completion with status 1 and no bus cycle.
    cyc_cycles = 0;
    exp_done.push_back({3'd0, 2'd1}); exp_grant.push_back(0);
    issue(0, 3'd1, 16'd2, 16'd1000, 16'd1001, 8'h01);
    wait_empty();
    exp_done.push_back({3'd0, 2'd1}); exp_grant.push_back(0);
    issue(0, 3'd1, 16'd0, 16'd1000, 16'd250, 8'h01);
    wait_empty();
    exp_done.push_back({3'd0, 2'd1}); exp_grant.push_back(0);
    issue(0, 3'd5, 16'd2, 16'd1000, 16'd250, 8'h01);
    wait_empty();
    check("invalid_no_cyc", cyc_cycles, 32'd0);
    // dc == per is the inclusive boundary and must be accepted.
    push_seq(0, 3'd3, 16'd1, 16'd500, 16'd500, 8'h5A, 2'd0);
    issue(0, 3'd3, 16'd1, 16'd500, 16'd500, 8'h5A);
    wait_empty();

    // Slave withholds ack on the period write: timeout after 15 cycles.
    nack_en = 1'b1; nack_reg = 3'd2;
    cyc_cycles = 0;
    push_bus(1'b1, 16'h0001, 16'd3);
    exp_done.push_back({3'd0, 2'd2}); exp_grant.push_back(0);
    issue(0, 3'd0, 16'd3, 16'd100, 16'd50, 8'h07);
    wait_empty();
    check("timeout_cyc_cycles", cyc_cycles, 32'd17);
    nack_en = 1'b0;

    // Read-back returns per-1: verify mismatch.
    rd_corrupt = 1'b1;
    push_seq(0, 3'd1, 16'd2, 16'd1000, 16'd250, 8'h16, 2'd3);
    issue(0, 3'd1, 16'd2, 16'd1000, 16'd250, 8'h16);
    wait_empty();
    rd_corrupt = 1'b0;

    // Reset during the duty write abandons the request silently.
    push_bus(1'b1, 16'h0011, 16'd5);
    push_bus(1'b1, 16'h0012, 16'd400);
    exp_grant.push_back(0);
    issue(0, 3'd2, 16'd5, 16'd400, 16'd100, 8'h03);
    n = 0;
    while (!(wb_cyc && wb_adr[2:0] == 3'd3) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("reach_w_dc", {31'd0, n < LIMIT}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_bus_idle("midrst");
    rst = 1'b0;
    check("midrst_prefix_consumed", exp_bus.size(), 32'd0);
    exp_bus.delete(); exp_done.delete(); exp_grant.delete();
    repeat (20) @(negedge clk);
    push_seq(0, 3'd2, 16'd5, 16'd400, 16'd100, 8'h03, 2'd0);
    issue(0, 3'd2, 16'd5, 16'd400, 16'd100, 8'h03);
    wait_empty();

    // Fresh reset puts the RR pointer at 0; two requesters contend.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) push_seq(0, 3'd2, 16'd1, 16'd10, 16'd10, 8'h01, 2'd0);
      else            push_seq(1, 3'd3, 16'd7, 16'd20, 16'd0, 8'h80, 2'd0);
    end
    @(negedge clk);
    set_fields(0, 3'd2, 16'd1, 16'd10, 16'd10, 8'h01);
    set_fields(1, 3'd3, 16'd7, 16'd20, 16'd0, 8'h80);
    req_valid = 2'b11;
    fork
      serve(0);
      serve(1);
    join
    wait_empty();
    check("grants_consumed", exp_grant.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
